// File: rtl/shift_sequencer_if.sv
// Handshake/bus bundle for shift_sequencer.
// Optional macro SHIFT_SEQ_RRX_EN adds the rrx request bit.
interface shift_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] val_rm;
  logic [7:0]  shift_amt;
  logic [1:0]  shift_type;
  logic        carry_in;
`ifdef SHIFT_SEQ_RRX_EN
  logic        rrx;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        carry_out;
  logic        busy;

  modport master (
    output in_valid, val_rm, shift_amt, shift_type, carry_in, out_ready,
`ifdef SHIFT_SEQ_RRX_EN
    output rrx,
`endif
    input  in_ready, out_valid, result, carry_out, busy
  );

  modport slave (
    input  in_valid, val_rm, shift_amt, shift_type, carry_in, out_ready,
`ifdef SHIFT_SEQ_RRX_EN
    input  rrx,
`endif
    output in_ready, out_valid, result, carry_out, busy
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle ARM register-specified shifter (LSL/LSR/ASR/ROR), STEP bits
// per cycle, with ARM shifter carry-out.
// Optional macro SHIFT_SEQ_RRX_EN: rrx request performs a one-cycle RRX.
module shift_sequencer #(
  parameter int STEP = 4
) (
  input  logic               clk,
  input  logic               rst,
  shift_sequencer_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [5:0] STEP6 = 6'(STEP);

  state_t      state, state_nx;
  logic [31:0] work;
  logic        carry;
  logic [5:0]  rem;
  logic [1:0]  typ;
  logic        accept;
  logic [5:0]  n_load;
  logic        ror_wrap;
  logic [31:0] sh_w;
  logic        sh_c;
  logic [5:0]  k;
  logic [5:0]  rem_nx;
`ifdef SHIFT_SEQ_RRX_EN
  logic        rrx_mode;
  logic        load_rrx;
`endif

  assign accept        = bus.in_valid && (state == IDLE);
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.result    = work;
  assign bus.carry_out = carry;

  // Clamp the Rs count; beyond 33 (32 for ASR) the outcome no longer changes.
  always_comb begin
    n_load = '0;
    case (bus.shift_type)
      2'b00, 2'b01: n_load = (bus.shift_amt > 8'd33) ? 6'd33 : bus.shift_amt[5:0];
      2'b10:        n_load = (bus.shift_amt > 8'd32) ? 6'd32 : bus.shift_amt[5:0];
      default:      n_load = {1'b0, bus.shift_amt[4:0]};
    endcase
`ifdef SHIFT_SEQ_RRX_EN
    load_rrx = bus.rrx && (bus.shift_type == 2'b11);
    if (load_rrx) n_load = 6'd1;
`endif
  end

  // ROR by a nonzero multiple of 32: no rotation, but C takes bit31.
  assign ror_wrap = (bus.shift_type == 2'b11) && (bus.shift_amt != 8'd0) &&
                    (bus.shift_amt[4:0] == 5'd0)
`ifdef SHIFT_SEQ_RRX_EN
                    && !load_rrx
`endif
                    ;

  // One SHIFT cycle: up to STEP single-bit shifts, gated by remaining count.
  always_comb begin
    sh_w = work;
    sh_c = carry;
    for (int i = 0; i < STEP; i++) begin
      if (6'(i) < rem) begin
        case (typ)
          2'b00:   begin sh_c = sh_w[31]; sh_w = {sh_w[30:0], 1'b0};     end
          2'b01:   begin sh_c = sh_w[0];  sh_w = {1'b0, sh_w[31:1]};     end
          2'b10:   begin sh_c = sh_w[0];  sh_w = {sh_w[31], sh_w[31:1]}; end
          default: begin sh_c = sh_w[0];  sh_w = {sh_w[0], sh_w[31:1]};  end
        endcase
      end
    end
`ifdef SHIFT_SEQ_RRX_EN
    if (rrx_mode) begin
      sh_w = {carry, work[31:1]};
      sh_c = work[0];
    end
`endif
    k      = (rem < STEP6) ? rem : STEP6;
    rem_nx = rem - k;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (n_load == 6'd0) ? DONE : SHIFT;
      SHIFT:   if (rem_nx == 6'd0) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Working register, carry and counter; frozen in DONE so outputs hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      work     <= '0;
      carry    <= 1'b0;
      rem      <= '0;
      typ      <= '0;
`ifdef SHIFT_SEQ_RRX_EN
      rrx_mode <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          work     <= bus.val_rm;
          carry    <= ror_wrap ? bus.val_rm[31] : bus.carry_in;
          rem      <= n_load;
          typ      <= bus.shift_type;
`ifdef SHIFT_SEQ_RRX_EN
          rrx_mode <= load_rrx;
`endif
        end
        SHIFT: begin
          work  <= sh_w;
          carry <= sh_c;
          rem   <= rem_nx;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed vector bench for shift_sequencer (STEP=4).
module tb_shift_sequencer;
  localparam int STEP = 4;
  localparam int NV   = 17;

  typedef struct {
    logic [1:0]  typ;
    logic [31:0] val;
    logic [7:0]  amt;
    logic        cin;
    logic [31:0] res;
    logic        c;
    int          n;     // clamped shift count; latency = ceil(n/STEP)+1
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  vec_t vt [NV];

  shift_sequencer_if bus ();

  shift_sequencer #(.STEP(STEP)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_op(input vec_t v, input int idx);
    int lat;
    int exp_lat;
    exp_lat = (v.n + STEP - 1) / STEP + 1;
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.val_rm     = v.val;
    bus.shift_amt  = v.amt;
    bus.shift_type = v.typ;
    bus.carry_in   = v.cin;
    bus.out_ready  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("v%0d_lat", idx), 32'(lat), 32'(exp_lat));
    check($sformatf("v%0d_res", idx), bus.result, v.res);
    check($sformatf("v%0d_c", idx), 32'(bus.carry_out), 32'(v.c));
  endtask

  initial begin
    vt[0]  = '{2'b00, 32'h00000001, 8'd4,   1'b0, 32'h00000010, 1'b0, 4};
    vt[1]  = '{2'b01, 32'h80000001, 8'd32,  1'b0, 32'h00000000, 1'b1, 32};
    vt[2]  = '{2'b01, 32'h80000001, 8'd33,  1'b1, 32'h00000000, 1'b0, 33};
    vt[3]  = '{2'b10, 32'h80000000, 8'd200, 1'b0, 32'hFFFFFFFF, 1'b1, 32};
    vt[4]  = '{2'b11, 32'h00000001, 8'd36,  1'b1, 32'h10000000, 1'b0, 4};
    vt[5]  = '{2'b11, 32'h80000001, 8'd32,  1'b0, 32'h80000001, 1'b1, 0};
    vt[6]  = '{2'b00, 32'h12345678, 8'd0,   1'b1, 32'h12345678, 1'b1, 0};
    vt[7]  = '{2'b00, 32'h80000001, 8'd32,  1'b0, 32'h00000000, 1'b1, 32};
    vt[8]  = '{2'b00, 32'hFFFFFFFF, 8'd40,  1'b1, 32'h00000000, 1'b0, 33};
    vt[9]  = '{2'b00, 32'h0000000F, 8'd1,   1'b1, 32'h0000001E, 1'b0, 1};
    vt[10] = '{2'b01, 32'h0000000F, 8'd3,   1'b0, 32'h00000001, 1'b1, 3};
    vt[11] = '{2'b10, 32'h80000010, 8'd5,   1'b0, 32'hFC000000, 1'b1, 5};
    vt[12] = '{2'b11, 32'h12345678, 8'd8,   1'b1, 32'h78123456, 1'b0, 8};
    vt[13] = '{2'b00, 32'h40000000, 8'd2,   1'b0, 32'h00000000, 1'b1, 2};
    vt[14] = '{2'b01, 32'h12345678, 8'd0,   1'b0, 32'h12345678, 1'b0, 0};
    vt[15] = '{2'b11, 32'h00000003, 8'd1,   1'b0, 32'h80000001, 1'b1, 1};
    vt[16] = '{2'b10, 32'h7FFFFFFF, 8'd32,  1'b1, 32'h00000000, 1'b0, 32};

    rst            = 1'b0;
    bus.in_valid   = 1'b0;
    bus.val_rm     = '0;
    bus.shift_amt  = '0;
    bus.shift_type = '0;
    bus.carry_in   = 1'b0;
    bus.out_ready  = 1'b0;
`ifdef SHIFT_SEQ_RRX_EN
    bus.rrx        = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_result",    bus.result,         32'd0);
    check("rst_carry",     32'(bus.carry_out), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) do_op(vt[i], i);

    // Zero-amount op held in DONE while the consumer stalls.
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.val_rm     = 32'hA5A5A5A5;
    bus.shift_amt  = 8'd0;
    bus.shift_type = 2'b01;
    bus.carry_in   = 1'b1;
    bus.out_ready  = 1'b0;
    @(negedge clk);
    bus.val_rm     = 32'hFFFFFFFF;   // offered but must not be taken in DONE
    bus.carry_in   = 1'b0;
    bus.shift_amt  = 8'd3;
    check("hold_valid0", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("hold%0d_res", i),   bus.result,         32'hA5A5A5A5);
      check($sformatf("hold%0d_c", i),     32'(bus.carry_out), 32'd1);
      check($sformatf("hold%0d_ready", i), 32'(bus.in_ready),  32'd0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    check("hold_rel_valid", 32'(bus.out_valid), 32'd0);
    check("hold_rel_ready", 32'(bus.in_ready),  32'd1);
    check("hold_rel_busy",  32'(bus.busy),      32'd0);

    // Reset in the middle of an LSL by 20.
    bus.in_valid   = 1'b1;
    bus.val_rm     = 32'h00000001;
    bus.shift_amt  = 8'd20;
    bus.shift_type = 2'b00;
    bus.carry_in   = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("mid_busy",  32'(bus.busy),     32'd1);
    check("mid_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready),  32'd1);
    check("mid_rst_res",   bus.result,         32'd0);
    check("mid_rst_c",     32'(bus.carry_out), 32'd0);
    check("mid_rst_busy",  32'(bus.busy),      32'd0);
    rst = 1'b1;
    do_op(vt[11], 100);

`ifdef SHIFT_SEQ_RRX_EN
    bus.rrx = 1'b1;
    do_op('{2'b11, 32'h00000003, 8'd7, 1'b1, 32'h80000001, 1'b1, 1}, 200);
    bus.rrx = 1'b0;
`endif

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle shifter for ARM register-specified shifts (shift amount from Rs[7:0]), in the EXE stage beside the immediate/constant-shift val2 path.
- Applies LSL/LSR/ASR/ROR over several cycles, STEP bits per cycle, and produces the ARM shifter carry-out.
- Valid/ready handshakes on both sides; the pipeline stalls while busy.

Parameters:
- STEP, 4, bits shifted per SHIFT cycle; legal values 1, 2, 4, 8.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept; high only in IDLE.
- val_rm  in  32  operand.
- shift_amt  in  8  Rs[7:0].
- shift_type  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
- carry_in  in  1  current CPSR C.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  32  shifted value.
- carry_out  out  1  shifter carry.
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- Reset (rst==0 at a clk edge), applied from any state including mid-operation: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, carry_out=0, remaining counter=0. Any in-flight operation is discarded.
- States:
  - IDLE: accept when in_valid && in_ready. Latch val_rm, type and carry_in into the working register and carry register. Load the count n: LSL/LSR use min(shift_amt,33); ASR uses min(shift_amt,32); ROR uses shift_amt[4:0]. If n==0 go to DONE, otherwise go to SHIFT.
  - SHIFT: each cycle, shift the working register by k=min(STEP,remaining) in the selected direction. Carry register takes the last bit shifted out. LSL/LSR fill with 0; ASR fills with bit31; ROR wraps. remaining -= k. When remaining reaches 0 go to DONE.
  - DONE: out_valid=1; result and carry_out are driven from registers. When out_ready, go to IDLE. Hold result and carry_out stable while out_ready is low.
- Zero and boundary cases:
  - shift_amt==0, any type: result=val_rm, carry_out=carry_in; out_valid the cycle after acceptance.
  - ROR with shift_amt!=0 and shift_amt[4:0]==0: result=val_rm, carry_out=val_rm[31], zero SHIFT cycles.
  - LSL by 32: result 0, C=bit0. LSL by >32: result 0, C=0. LSR mirrors this with bit31.
  - ASR by >=32: result all bit31, C=bit31.
  - These fall out of the clamped iterative shift; no special-casing except the ROR case above.
- Latency from the acceptance edge to out_valid: ceil(n/STEP)+1 cycles.
- in_ready stays low from acceptance until the cycle after the DONE handshake. No back-to-back acceptance in the same cycle as the output handshake.
- Outputs are registered only; no combinational path from the inputs to the outputs.

Optional Feature:
- Macro SHIFT_SEQ_RRX_EN.
- Defined: adds input port rrx (1 bit). If rrx && shift_type==11 at acceptance:
  - one SHIFT cycle regardless of shift_amt and STEP;
  - result={carry_in, val_rm[31:1]}, carry_out=val_rm[0].
- Undefined: the rrx port is absent; ROR follows the register-shift rules only.

Test Plan:
- LSL, val_rm=0x00000001, shift_amt=4, STEP=4, out_ready=1 -> out_valid 2 cycles after acceptance; result=0x00000010, carry_out=0.
- LSR, val_rm=0x80000001, shift_amt=32 -> 8 SHIFT cycles; result=0x00000000, carry_out=1. Repeat with shift_amt=33 -> result=0, carry_out=0.
- ASR, val_rm=0x80000000, shift_amt=200 -> result=0xFFFFFFFF, carry_out=1, 8 SHIFT cycles.
- ROR, val_rm=0x00000001, shift_amt=36 -> result=0x10000000, carry_out=0. ROR, shift_amt=32 -> result=val_rm, carry_out=val_rm[31], out_valid next cycle.
- shift_amt=0, carry_in=1 -> result=val_rm, carry_out=1. Hold out_ready=0 for 3 cycles: out_valid, result and carry_out stay stable and in_ready=0. Raise out_ready -> IDLE the next cycle.
- Assert rst=0 during SHIFT of an LSL by 20 -> next edge: IDLE, out_valid=0, result=0, in_ready=1. A new operation then completes correctly.
